// File: rtl/etapa_if_id_queue.sv
// DEPTH-entry IF/ID instruction queue with valid/ready on both sides; head visible one edge after push.
// Optional stall/flush statistics counters when ETAPA_IF_ID_QUEUE_STATS_EN is defined.
module etapa_if_id_queue #(
  parameter  int NBITS = 32,
  parameter  int DEPTH = 4,
  localparam int CNTW  = $clog2(DEPTH+1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_IF_ID_Flush,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [NBITS-1:0] i_PC4,
  input  logic [NBITS-1:0] i_PC8,
  input  logic [NBITS-1:0] i_Instruction,
  output logic             o_pop_valid,
  input  logic             i_IF_ID_Write,
  output logic [NBITS-1:0] o_PC4,
  output logic [NBITS-1:0] o_PC8,
  output logic [NBITS-1:0] o_Instruction,
`ifdef ETAPA_IF_ID_QUEUE_STATS_EN
  output logic [31:0]      o_stall_cycles,
  output logic [15:0]      o_flush_count,
`endif
  output logic [CNTW-1:0]  o_count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [NBITS-1:0] pc4;
    logic [NBITS-1:0] pc8;
    logic [NBITS-1:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // Ready/valid come from registered count only, so there is no input-to-output path.
  assign full         = (count == CNTW'(DEPTH));
  assign empty        = (count == '0);
  assign o_push_ready = !full;
  assign o_pop_valid  = !empty;
  assign push         = i_push_valid & !full;
  assign pop          = i_IF_ID_Write & !empty;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_IF_ID_Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_IF_ID_Flush && push)
      mem[wr_ptr] <= '{pc4: i_PC4, pc8: i_PC8, instr: i_Instruction};
  end

  // Empty queue presents a zero bubble (NOP) to decode.
  assign head          = empty ? '0 : mem[rd_ptr];
  assign o_PC4         = head.pc4;
  assign o_PC8         = head.pc8;
  assign o_Instruction = head.instr;
  assign o_count       = count;

`ifdef ETAPA_IF_ID_QUEUE_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_cycles <= '0;
      o_flush_count  <= '0;
    end else begin
      if (i_push_valid && full && !(&o_stall_cycles))
        o_stall_cycles <= o_stall_cycles + 1'b1;
      if (i_IF_ID_Flush && !(&o_flush_count))
        o_flush_count <= o_flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_etapa_if_id_queue.sv
// Directed bench for etapa_if_id_queue: a queue-based reference checked every cycle plus literal spot checks.
module tb_etapa_if_id_queue;

  localparam int NBITS = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH+1);

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_IF_ID_Flush = 1'b0;
  logic             i_push_valid = 1'b0;
  logic             o_push_ready;
  logic [NBITS-1:0] i_PC4 = '0;
  logic [NBITS-1:0] i_PC8 = '0;
  logic [NBITS-1:0] i_Instruction = '0;
  logic             o_pop_valid;
  logic             i_IF_ID_Write = 1'b0;
  logic [NBITS-1:0] o_PC4;
  logic [NBITS-1:0] o_PC8;
  logic [NBITS-1:0] o_Instruction;
  logic [CNTW-1:0]  o_count;
`ifdef ETAPA_IF_ID_QUEUE_STATS_EN
  logic [31:0]      o_stall_cycles;
  logic [15:0]      o_flush_count;
`endif

  etapa_if_id_queue #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_IF_ID_Flush(i_IF_ID_Flush),
    .i_push_valid(i_push_valid),
    .o_push_ready(o_push_ready),
    .i_PC4(i_PC4),
    .i_PC8(i_PC8),
    .i_Instruction(i_Instruction),
    .o_pop_valid(o_pop_valid),
    .i_IF_ID_Write(i_IF_ID_Write),
    .o_PC4(o_PC4),
    .o_PC8(o_PC8),
    .o_Instruction(o_Instruction),
`ifdef ETAPA_IF_ID_QUEUE_STATS_EN
    .o_stall_cycles(o_stall_cycles),
    .o_flush_count(o_flush_count),
`endif
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] pc8;
    logic [31:0] ins;
  } ent_t;

  int   vectors = 0;
  int   miscompares = 0;
  ent_t mq[$];
  bit   known = 0;
  int   m_stall = 0;
  int   m_flush = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain FIFO of entries, updated from the inputs seen at each edge.
  always @(posedge i_clk) begin
    bit can_push, can_pop;
    can_push = i_push_valid && (mq.size() < DEPTH);
    can_pop  = i_IF_ID_Write && (mq.size() > 0);
    if (i_reset) begin
      mq.delete();
      known   = 1;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (i_push_valid && mq.size() == DEPTH && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (i_IF_ID_Flush && m_flush != 16'hFFFF) m_flush++;
      if (i_IF_ID_Flush) mq.delete();
      else begin
        if (can_pop)  void'(mq.pop_front());
        if (can_push) mq.push_back('{pc4: i_PC4, pc8: i_PC8, ins: i_Instruction});
      end
    end
  end

  always @(negedge i_clk) begin
    ent_t h;
    if (known) begin
      h = (mq.size() > 0) ? mq[0] : '0;
      chk("m_count", 32'(o_count), 32'(mq.size()));
      chk("m_pop_valid", 32'(o_pop_valid), 32'(mq.size() > 0));
      chk("m_push_ready", 32'(o_push_ready), 32'(mq.size() < DEPTH));
      chk("m_pc4", o_PC4, h.pc4);
      chk("m_pc8", o_PC8, h.pc8);
      chk("m_instr", o_Instruction, h.ins);
`ifdef ETAPA_IF_ID_QUEUE_STATS_EN
      chk("m_stall", o_stall_cycles, 32'(m_stall));
      chk("m_flushcnt", 32'(o_flush_count), 32'(m_flush));
`endif
    end
  end

  // Drive one cycle of inputs, then return just after the edge.
  task automatic step(input bit pv, input logic [31:0] ins, input bit wr, input bit fl, input bit rst);
    i_push_valid  = pv;
    i_Instruction = ins;
    i_PC4         = ins + 32'h1000;
    i_PC8         = ins + 32'h2000;
    i_IF_ID_Write = wr;
    i_IF_ID_Flush = fl;
    i_reset       = rst;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [31:0] fill [4];
    fill = '{32'h11, 32'h22, 32'h33, 32'h44};

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_pop_valid", 32'(o_pop_valid), 0);
    chk("rst_push_ready", 32'(o_push_ready), 1);
    chk("rst_instr", o_Instruction, 0);

    foreach (fill[i]) step(1, fill[i], 0, 0, 0);
    chk("fill_count", 32'(o_count), 4);
    chk("fill_push_ready", 32'(o_push_ready), 0);
    chk("fill_head", o_Instruction, 32'h11);
    chk("fill_pc4", o_PC4, 32'h1011);

    step(1, 32'h55, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    chk("drop5_head", o_Instruction, 32'h44);
    chk("drop5_count", 32'(o_count), 1);
    step(0, 0, 1, 0, 0);
    chk("drained_instr", o_Instruction, 0);

    step(1, 32'h11, 0, 0, 0);
    step(1, 32'h22, 0, 0, 0);
    step(1, 32'h66, 1, 0, 0);
    chk("pp_count", 32'(o_count), 2);
    chk("pp_head", o_Instruction, 32'h22);
    for (int i = 0; i < 5; i++) step(1, 32'h67 + i, 1, 0, 0);
    chk("wrap_head", o_Instruction, 32'h6A);
    chk("wrap_pc8", o_PC8, 32'h206A);
    step(0, 0, 1, 0, 0);
    chk("wrap_next", o_Instruction, 32'h6B);
    step(0, 0, 1, 0, 0);

    step(1, 32'hA5, 1, 0, 0);
    chk("epp_count", 32'(o_count), 1);
    chk("epp_head", o_Instruction, 32'hA5);

    step(1, 32'hB1, 0, 0, 0);
    step(1, 32'hB2, 0, 0, 0);
    chk("pre_flush_count", 32'(o_count), 3);
    step(1, 32'hC0, 1, 1, 0);
    chk("flush_count", 32'(o_count), 0);
    chk("flush_instr", o_Instruction, 0);
    chk("flush_pc4", o_PC4, 0);
    chk("flush_push_ready", 32'(o_push_ready), 1);
    step(1, 32'h77, 0, 0, 0);
    chk("post_flush_head", o_Instruction, 32'h77);
    step(1, 32'h78, 0, 0, 0);

    step(0, 0, 0, 1, 1);
    chk("rst_beats_flush", 32'(o_count), 0);
`ifdef ETAPA_IF_ID_QUEUE_STATS_EN
    chk("stat_flush_after_rst", 32'(o_flush_count), 0);
`endif
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
`ifdef ETAPA_IF_ID_QUEUE_STATS_EN
    chk("stat_flush_3", 32'(o_flush_count), 3);
`endif
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/etapa_if_id_queue.md
Name: etapa_if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Replaces it with a DEPTH-entry instruction queue between fetch (IF) and decode (ID), using a valid/ready handshake on both sides.
- Fetch can run ahead of a stalled decode. Flush discards every queued entry in one cycle.
- Each entry is {PC4, PC8, Instruction}. Decode always sees the head entry; it sees a zero bubble (NOP) when the queue is empty.

Parameters:
- NBITS, 32, width of PC4, PC8 and Instruction fields.
- DEPTH, 4, number of queue entries; power of two, >= 2.
- CNTW, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_reset  input  1  synchronous, active-high reset.
- i_IF_ID_Flush  input  1  discard all entries (branch/jump taken).
- i_push_valid  input  1  fetch presents a new entry.
- o_push_ready  output  1  queue can accept an entry; equals !full.
- i_PC4  input  NBITS  fetch PC+4.
- i_PC8  input  NBITS  fetch PC+8.
- i_Instruction  input  NBITS  fetched instruction word.
- o_pop_valid  output  1  head entry valid; equals !empty.
- i_IF_ID_Write  input  1  decode consumes the head entry (pop request / pop-ready).
- o_PC4  output  NBITS  head PC+4; 0 when empty.
- o_PC8  output  NBITS  head PC+8; 0 when empty.
- o_Instruction  output  NBITS  head instruction; 0 (NOP) when empty.
- o_count  output  CNTW  current occupancy, 0..DEPTH.

Behaviour:
- Reset (i_reset=1 at posedge): wr_ptr=0, rd_ptr=0, count=0.
  - Consequently o_pop_valid=0, o_push_ready=1, o_PC4/o_PC8/o_Instruction=0, o_count=0.
  - Storage contents need not be cleared.
  - Reset overrides flush, push and pop in the same cycle.
- push = i_push_valid & o_push_ready; pop = i_IF_ID_Write & o_pop_valid.
- Push writes {i_PC4, i_PC8, i_Instruction} to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop increments rd_ptr modulo DEPTH.
- Count update:
  - push & !pop: count+1.
  - pop & !push: count-1.
  - both: unchanged.
- Pointer wrap from DEPTH-1 to 0 is natural (log2(DEPTH)-bit pointers).
- Latency: an entry pushed at edge N appears on the outputs after edge N (visible during cycle N+1). No same-cycle bypass from push to output.
- Empty queue with push and i_IF_ID_Write both high: pop is ignored (o_pop_valid=0). After the edge, count=1 and the new entry is at the head.
- Full queue: o_push_ready=0, so i_push_valid is ignored even if a pop occurs in the same cycle. o_push_ready depends only on registered count, never on i_IF_ID_Write.
- Outputs are the head entry when count>0, else all zero.
  - The zero-forcing is a mux on registered state only.
  - No combinational path from any input to any output.
- Flush (i_IF_ID_Flush=1 at posedge): wr_ptr=rd_ptr=0, count=0. Any push or pop in that cycle is discarded. Outputs read zero from the next cycle.
- Flush and reset both assert only at a clock edge; there is no asynchronous clear path.
- Priority order: reset > flush > push/pop.

Optional Feature:
- Macro: ETAPA_IF_ID_QUEUE_STATS_EN.
- When defined, two extra output ports are added:
  - o_stall_cycles (32 bits): counts cycles with i_push_valid=1 and o_push_ready=0.
  - o_flush_count (16 bits): counts cycles with i_IF_ID_Flush=1 and i_reset=0.
- Both counters saturate at all-ones, reset to 0 on i_reset, and are not cleared by flush.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: i_reset=1 for 2 cycles, then 0 -> o_count=0, o_pop_valid=0, o_push_ready=1, o_Instruction=0.
- Fill: DEPTH=4, push 4 entries with Instruction=0x11,0x22,0x33,0x44 and i_IF_ID_Write=0.
  - Response: o_count=4, o_push_ready=0, o_Instruction=0x11.
  - A 5th push with Instruction=0x55 is dropped: after 3 pops, head=0x44, not 0x55.
- Simultaneous push/pop at count=2 (head 0x11, next 0x22): push 0x66 -> count stays 2, head becomes 0x22. Continue cycling for >DEPTH pushes to verify pointer wrap and FIFO order.
- Empty push+pop: count=0, i_push_valid=1 (Instruction=0xA5), i_IF_ID_Write=1 -> next cycle count=1, o_Instruction=0xA5.
- Flush mid-stream: count=3, then assert flush with push and pop both high.
  - Next cycle: count=0, all outputs 0, o_push_ready=1.
  - Next push 0x77 appears as head one cycle later.
- Reset beats flush: i_reset=1 and i_IF_ID_Flush=1 with count=2 -> count=0. With ETAPA_IF_ID_QUEUE_STATS_EN defined, o_flush_count stays 0; 3 flush-only cycles later it reads 3.
